// File: rtl/mux_scan_controller_pkg.sv
// rtl/mux_scan_controller_pkg.sv - shared constants and state type for the mux scan controller
package mux_scan_controller_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_controller_if.sv
// rtl/mux_scan_controller_if.sv - control, mux select and snapshot signals of the scan controller
interface mux_scan_controller_if
    import mux_scan_controller_pkg::*;
#(
    parameter int DWELL_W = 8
);
    logic               i_start;
    logic               i_stop;
    logic               i_cont;
    logic [NUM_CH-1:0]  i_mask;
    logic [DWELL_W-1:0] i_dwell;
    logic               i_sample;
    logic [SEL_W-1:0]   o_con;
    logic               o_busy;
    logic [NUM_CH-1:0]  o_snap;
    logic [NUM_CH-1:0]  o_ch_valid;
    logic               o_done;

    // master is the scan controller itself; slave is the surrounding control logic and mux
    modport master (
        input  i_start, i_stop, i_cont, i_mask, i_dwell, i_sample,
        output o_con, o_busy, o_snap, o_ch_valid, o_done
    );

    modport slave (
        output i_start, i_stop, i_cont, i_mask, i_dwell, i_sample,
        input  o_con, o_busy, o_snap, o_ch_valid, o_done
    );
endinterface

// File: rtl/mux_scan_next_ch.sv
// rtl/mux_scan_next_ch.sv - priority finder for the next and lowest enabled channel
module mux_scan_next_ch
    import mux_scan_controller_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    output logic [SEL_W-1:0]  nxt_o,
    output logic              found_o,
    output logic [SEL_W-1:0]  lowest_o
);
    // Scanning downward leaves the smallest qualifying index as the final assignment.
    always_comb begin
        nxt_o    = CH_A;
        found_o  = 1'b0;
        lowest_o = CH_A;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lowest_o = SEL_W'(i);
                if (i > int'(cur_i)) begin
                    nxt_o   = SEL_W'(i);
                    found_o = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mux_scan_controller.sv
// rtl/mux_scan_controller.sv - sweeps enabled mux channels, settles, dwells and snapshots o_a
module mux_scan_controller
    import mux_scan_controller_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = 1
) (
    input  logic                  clk,
    input  logic                  rs,
    mux_scan_controller_if.master bus
);
    localparam int SET_W = $clog2(SETTLE + 2);
    localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_t ENTRY_ST = (SETTLE > 0) ? ST_SETTLE : ST_HOLD;

    state_t             state_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [DWELL_W-1:0] dwell_m1_q;
    logic               cont_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   con_q;
    logic               busy_q;
    logic               done_q;
    logic [NUM_CH-1:0]  snap_q;
    logic [NUM_CH-1:0]  valid_q;

    logic [NUM_CH-1:0]  find_mask;
    logic [SEL_W-1:0]   nxt_ch;
    logic [SEL_W-1:0]   low_ch;
    logic               nxt_found;
    logic [DWELL_W-1:0] dwell_in_m1;
    logic [DWELL_W-1:0] dwell_m1_d;
    logic [CNT_W-1:0]   entry_cnt_d;

    // In IDLE the config is not latched yet, so the finder and counters look at the live inputs.
    assign find_mask   = (state_q == ST_IDLE) ? bus.i_mask : mask_q;
    assign dwell_in_m1 = (bus.i_dwell == '0) ? '0 : bus.i_dwell - DWELL_W'(1);
    assign dwell_m1_d  = (state_q == ST_IDLE) ? dwell_in_m1 : dwell_m1_q;
    assign entry_cnt_d = (SETTLE > 0) ? SETTLE_M1 : CNT_W'(dwell_m1_d);

    mux_scan_next_ch u_next_ch (
        .mask_i   (find_mask),
        .cur_i    (con_q),
        .nxt_o    (nxt_ch),
        .found_o  (nxt_found),
        .lowest_o (low_ch)
    );

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            dwell_m1_q <= '0;
            cont_q     <= 1'b0;
            cnt_q      <= '0;
            con_q      <= CH_A;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            snap_q     <= '0;
            valid_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start && !bus.i_stop) begin
                        mask_q     <= bus.i_mask;
                        cont_q     <= bus.i_cont;
                        dwell_m1_q <= dwell_in_m1;
                        if (bus.i_mask != '0) begin
                            con_q   <= low_ch;
                            valid_q <= '0;
                            busy_q  <= 1'b1;
                            cnt_q   <= entry_cnt_d;
                            state_q <= ENTRY_ST;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (bus.i_stop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        cnt_q   <= CNT_W'(dwell_m1_d);
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.i_stop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        snap_q[con_q]  <= bus.i_sample;
                        valid_q[con_q] <= 1'b1;
                        if (nxt_found) begin
                            con_q   <= nxt_ch;
                            cnt_q   <= entry_cnt_d;
                            state_q <= ENTRY_ST;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!bus.i_stop && cont_q && (mask_q != '0)) begin
                        con_q   <= low_ch;
                        valid_q <= '0;
                        busy_q  <= 1'b1;
                        cnt_q   <= entry_cnt_d;
                        state_q <= ENTRY_ST;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_con      = con_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_snap     = snap_q;
    assign bus.o_ch_valid = valid_q;
    assign bus.o_done     = done_q;
endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
Sequencer that sits directly upstream of the 4:1 reset-able multiplexor. It drives the multiplexor's 2-bit select (i_con) and consumes its single-bit output (o_a). It sweeps a masked set of the four channels; for each channel it waits a settle time, dwells, then samples the mux output into a 4-bit snapshot. Supports single-sweep and continuous modes, with start, stop and done signalling toward the surrounding control logic.

Parameters:
DWELL_W, 8, width of the dwell count input and dwell counter.
SETTLE, 1, cycles after each select change before dwell starts; 0 means the settle phase is skipped.

Ports:
clk  in  1  system clock, rising edge.
rs  in  1  reset, asynchronous, active-high.
i_start  in  1  start-sweep request, sampled in IDLE only.
i_stop  in  1  abort request.
i_cont  in  1  continuous mode; latched at start.
i_mask  in  4  channel enables; bit0=a, bit1=b, bit2=c, bit3=d; latched at start.
i_dwell  in  DWELL_W  dwell cycles per channel; 0 is treated as 1; latched at start.
i_sample  in  1  mux output (o_a) fed back.
o_con  out  2  select to mux i_con; 00=a, 01=b, 10=c, 11=d.
o_busy  out  1  high in SETTLE and HOLD.
o_snap  out  4  sampled value per channel.
o_ch_valid  out  4  channel sampled in the current sweep.
o_done  out  1  one-cycle pulse at end of each sweep.

Behaviour:
- Reset (async, rs=1): state IDLE; o_con=00, o_busy=0, o_snap=0000, o_ch_valid=0000, o_done=0. All counters and latched config are cleared. Reset mid-sweep aborts immediately; no o_done is produced.
- States: IDLE, SETTLE, HOLD, DONE. o_done is registered and is high only in DONE.
- IDLE:
  - i_start=1 and i_mask!=0: latch mask, dwell and cont; o_con <= lowest enabled channel; o_ch_valid <= 0000; go to SETTLE, or to HOLD if SETTLE=0.
  - i_start=1 and i_mask=0: go to DONE (empty sweep, o_snap unchanged).
  - i_stop=1 overrides i_start.
- SETTLE: lasts exactly SETTLE cycles, then go to HOLD with the dwell counter loaded to max(dwell,1).
- HOLD: lasts exactly max(dwell,1) cycles. On the clock edge ending the last HOLD cycle:
  - o_snap[o_con] <= i_sample and o_ch_valid[o_con] <= 1.
  - If an enabled channel exists above o_con: o_con <= next enabled channel, go to SETTLE (or HOLD if SETTLE=0).
  - Otherwise go to DONE.
- DONE (1 cycle):
  - If cont=1 and mask!=0: o_con <= lowest enabled channel, o_ch_valid <= 0000, go to SETTLE/HOLD. The new sweep's o_con change coincides with the o_done cycle.
  - Otherwise go to IDLE.
- Timing: cycle t = i_start seen. Sweep of N enabled channels gives o_done high at cycle t+1+N*(SETTLE+D), where D = max(dwell,1). o_con is stable for the whole SETTLE+HOLD window of each channel.
- i_stop in SETTLE, HOLD or DONE: next state IDLE, o_busy=0, no o_done. o_con holds its last value. o_snap and o_ch_valid keep the bits already captured; an in-flight channel is not captured. A stop coinciding with the final HOLD edge takes priority over the capture.
- i_start while not IDLE is ignored. Config inputs may change mid-sweep without effect.
- o_busy=1 in SETTLE and HOLD; 0 in IDLE and DONE.

Decomposition:
- Shared package: state encoding constants (IDLE, SETTLE, HOLD, DONE), channel count 4, select width 2, channel-index constants CH_A..CH_D.
- One natural sub-module, mux_scan_next_ch: combinational priority finder. Inputs: mask and current index. Outputs: next enabled index above current, a found flag, and the lowest enabled index.

Test Plan:
1. Mux inputs a=1, b=0, c=0, d=1; mask=1111, dwell=2, SETTLE=1, start at cycle 0 -> o_con walks 00,01,10,11 every 3 cycles; o_done at cycle 13; o_snap=1001; o_ch_valid=1111.
2. mask=1010, dwell=0 -> only channels b and d visited with dwell 1 (2 cycles each); o_done at cycle 5; o_snap bit1=0, bit3=1; bits 0 and 2 unchanged.
3. mask=0000 with start -> o_done pulses at cycle 1; o_busy never high; o_snap unchanged.
4. i_stop asserted at cycle 5 of scenario 1 -> IDLE at cycle 6; o_ch_valid=0001; o_done never pulses; o_con=01 held.
5. cont=1, mask=0001, dwell=3 -> o_done every 5 cycles (cycles 5, 10, 15…); flipping input a between sweeps updates o_snap[0]; i_start during the sweep is ignored.
6. rs pulsed asynchronously mid-HOLD (between clock edges) -> all outputs return to reset values immediately; the next start runs a normal sweep.
